bsg_manycore_loader_arbiter: RTL and testbench

Shares the single host-side loader link of the manycore array among num_req_p host requesters, e.g. program loader, MMIO bridge and DMA engine. Each cycle it grants one request packet in round-robin order into a one-entry output buffer. It tags the packet's load_id with the requester index, meters outstanding requests per requester with credit counters, and routes returning responses back to their originating requester by tag.

---
 rtl/bsg_manycore_loader_arbiter_if.sv | 48 ++++
 rtl/bsg_manycore_loader_arbiter.sv | 168 ++++++++++++++++
 tb/tb_bsg_manycore_loader_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/bsg_manycore_loader_arbiter_if.sv
// rtl/bsg_manycore_loader_arbiter_if.sv - request, link, return and status bundle of the loader arbiter
interface bsg_manycore_loader_arbiter_if #(
    parameter int num_req_p       = 3,
    parameter int packet_width_p  = 128,
    parameter int return_width_p  = 64,
    parameter int load_id_width_p = 5,
    parameter int max_out_p       = 8
);
    localparam int cnt_width_lp = $clog2(max_out_p + 1);

    // requester side
    logic [num_req_p-1:0]                req_v_i;
    logic [num_req_p*packet_width_p-1:0] req_packet_i;
    logic [num_req_p-1:0]                req_ready_o;

    // loader link side
    logic                      link_v_o;
    logic [packet_width_p-1:0] link_packet_o;
    logic                      link_ready_i;
    logic                      link_return_v_i;
    logic [return_width_p-1:0] link_return_data_i;
    logic [load_id_width_p-1:0] link_return_id_i;
    logic                      link_return_yumi_o;

    // return fan-out to requesters
    logic [num_req_p-1:0]      ret_v_o;
    logic [return_width_p-1:0] ret_data_o;
    logic [num_req_p-1:0]      ret_yumi_i;

    // status
    logic [num_req_p*cnt_width_lp-1:0] out_credits_o;
    logic                              idle_o;
    logic                              err_o;

    modport slave (
        input  req_v_i, req_packet_i, link_ready_i, link_return_v_i,
               link_return_data_i, link_return_id_i, ret_yumi_i,
        output req_ready_o, link_v_o, link_packet_o, link_return_yumi_o,
               ret_v_o, ret_data_o, out_credits_o, idle_o, err_o
    );

    modport master (
        output req_v_i, req_packet_i, link_ready_i, link_return_v_i,
               link_return_data_i, link_return_id_i, ret_yumi_i,
        input  req_ready_o, link_v_o, link_packet_o, link_return_yumi_o,
               ret_v_o, ret_data_o, out_credits_o, idle_o, err_o
    );
endinterface

// File: rtl/bsg_manycore_loader_arbiter.sv
// rtl/bsg_manycore_loader_arbiter.sv - round-robin loader link arbiter with tagging, credits and return routing (LOADER_ARB_FIXED_PRIO_EN selects fixed priority)
module bsg_manycore_loader_arbiter #(
    parameter int num_req_p       = 3,
    parameter int packet_width_p  = 128,
    parameter int return_width_p  = 64,
    parameter int load_id_width_p = 5,
    parameter int load_id_lsb_p   = 0,
    parameter int max_out_p       = 8
) (
    input logic clk_i,
    input logic reset_i,
    bsg_manycore_loader_arbiter_if.slave bus
);
    localparam int tag_width_lp = $clog2(num_req_p);
    localparam int cnt_width_lp = $clog2(max_out_p + 1);
    localparam int tag_lsb_lp   = load_id_lsb_p + load_id_width_p - tag_width_lp;

    logic                      link_v_q, link_v_d;
    logic [packet_width_p-1:0] link_packet_q, link_packet_d;
    logic [cnt_width_lp-1:0]   cnt_q [num_req_p];
    logic [cnt_width_lp-1:0]   cnt_d [num_req_p];
    logic                      err_q, err_d;
`ifndef LOADER_ARB_FIXED_PRIO_EN
    logic [tag_width_lp-1:0]   last_q, last_d;
`endif

    logic                      can_load;
    logic [num_req_p-1:0]      eligible;
    logic                      grant_v;
    logic [tag_width_lp-1:0]   grant_idx;
    logic [packet_width_p-1:0] tagged_packet;
    logic [tag_width_lp-1:0]   ret_tag;
    logic                      ret_tag_ok;
    logic [num_req_p-1:0]      ret_v;
    logic                      ret_yumi;
    logic                      unused_id_bits;

    // only the tag bits of the return id matter for routing
    assign unused_id_bits = ^bus.link_return_id_i;

    // pick the winning requester: nearest eligible index after the last grant (or lowest index in fixed mode)
    always_comb begin
        int d;
        int best_d;
        can_load  = ~link_v_q | bus.link_ready_i;
        grant_v   = 1'b0;
        grant_idx = '0;
        d         = 0;
        best_d    = num_req_p;
        for (int i = 0; i < num_req_p; i++) begin
            eligible[i] = bus.req_v_i[i] & (cnt_q[i] < cnt_width_lp'(max_out_p));
`ifdef LOADER_ARB_FIXED_PRIO_EN
            d = i;
`else
            d = (i + num_req_p - 1 - int'(last_q)) % num_req_p;
`endif
            if (eligible[i] && (d < best_d)) begin
                best_d    = d;
                grant_v   = can_load;
                grant_idx = tag_width_lp'(i);
            end
        end
    end

    // select the winner's packet and overwrite the top load_id bits with its index
    always_comb begin
        tagged_packet = '0;
        for (int i = 0; i < num_req_p; i++) begin
            if (grant_idx == tag_width_lp'(i)) begin
                tagged_packet = bus.req_packet_i[i*packet_width_p +: packet_width_p];
            end
        end
        tagged_packet[tag_lsb_lp +: tag_width_lp] = grant_idx;
    end

    // steer the return to its requester by tag; unknown tags are swallowed immediately
    always_comb begin
        logic sel_yumi;
        ret_tag    = bus.link_return_id_i[load_id_width_p-1 -: tag_width_lp];
        ret_tag_ok = (32'(ret_tag) < num_req_p);
        sel_yumi   = 1'b0;
        for (int i = 0; i < num_req_p; i++) begin
            ret_v[i] = bus.link_return_v_i & ret_tag_ok & (ret_tag == tag_width_lp'(i));
            sel_yumi = sel_yumi | (ret_v[i] & bus.ret_yumi_i[i]);
        end
        ret_yumi = reset_i & (ret_tag_ok ? sel_yumi : bus.link_return_v_i);
    end

    // next-state for buffer, credits, error flag and rr pointer
    always_comb begin
        logic inc;
        logic dec;
        logic zero_hit;
        link_v_d      = link_v_q;
        link_packet_d = link_packet_q;
        err_d         = err_q;
        zero_hit      = 1'b0;
        inc           = 1'b0;
        dec           = 1'b0;
        if (can_load) begin
            link_v_d = grant_v;
            if (grant_v) begin
                link_packet_d = tagged_packet;
            end
        end
        for (int i = 0; i < num_req_p; i++) begin
            inc      = grant_v & (grant_idx == tag_width_lp'(i));
            dec      = ret_yumi & ret_tag_ok & (ret_tag == tag_width_lp'(i)) & (cnt_q[i] != '0);
            zero_hit = zero_hit | (ret_yumi & ret_tag_ok & (ret_tag == tag_width_lp'(i)) & (cnt_q[i] == '0));
            cnt_d[i] = cnt_q[i];
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + cnt_width_lp'(1);
            end else if (dec && !inc) begin
                cnt_d[i] = cnt_q[i] - cnt_width_lp'(1);
            end
        end
        if ((ret_yumi && !ret_tag_ok) || zero_hit) begin
            err_d = 1'b1;
        end
`ifndef LOADER_ARB_FIXED_PRIO_EN
        last_d = grant_v ? grant_idx : last_q;
`endif
    end

    // state registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            link_v_q      <= 1'b0;
            link_packet_q <= '0;
            err_q         <= 1'b0;
            for (int i = 0; i < num_req_p; i++) begin
                cnt_q[i] <= '0;
            end
`ifndef LOADER_ARB_FIXED_PRIO_EN
            last_q        <= tag_width_lp'(num_req_p - 1);
`endif
        end else begin
            link_v_q      <= link_v_d;
            link_packet_q <= link_packet_d;
            err_q         <= err_d;
            for (int i = 0; i < num_req_p; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
`ifndef LOADER_ARB_FIXED_PRIO_EN
            last_q        <= last_d;
`endif
        end
    end

    // drive outputs from registered state and the combinational grant/return paths
    always_comb begin
        logic all_zero;
        all_zero          = 1'b1;
        bus.out_credits_o = '0;
        for (int i = 0; i < num_req_p; i++) begin
            bus.req_ready_o[i] = reset_i & grant_v & (grant_idx == tag_width_lp'(i));
            bus.out_credits_o[i*cnt_width_lp +: cnt_width_lp] = cnt_q[i];
            all_zero = all_zero & (cnt_q[i] == '0);
        end
        bus.link_v_o           = link_v_q;
        bus.link_packet_o      = link_packet_q;
        bus.link_return_yumi_o = ret_yumi;
        bus.ret_v_o            = ret_v;
        bus.ret_data_o         = bus.link_return_data_i;
        bus.idle_o             = ~link_v_q & all_zero;
        bus.err_o              = err_q;
    end
endmodule

// File: tb/tb_bsg_manycore_loader_arbiter.sv
// tb/tb_bsg_manycore_loader_arbiter.sv - randomized self-checking bench with a behavioural model of the loader arbiter
module tb_bsg_manycore_loader_arbiter;
    localparam int N    = 3;
    localparam int PW   = 128;
    localparam int RW   = 64;
    localparam int LIDW = 5;
    localparam int MAX  = 8;
    localparam int CW   = 4;
    localparam int TPOS = 3;

    logic clk = 1'b0;
    logic reset_i = 1'b0;
    always #5 clk = ~clk;

    bsg_manycore_loader_arbiter_if #(
        .num_req_p(N), .packet_width_p(PW), .return_width_p(RW),
        .load_id_width_p(LIDW), .max_out_p(MAX)
    ) bus ();

    bsg_manycore_loader_arbiter #(
        .num_req_p(N), .packet_width_p(PW), .return_width_p(RW),
        .load_id_width_p(LIDW), .load_id_lsb_p(0), .max_out_p(MAX)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset_i),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // model state
    int          m_cnt [N];
    bit          m_full;
    logic [PW-1:0] m_pkt;
    int          m_last;
    bit          m_err;
    logic [PW-1:0] pk [N];

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] rand_pkt();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_full = 0;
        m_pkt  = '0;
        m_last = N - 1;
        m_err  = 0;
    endtask

    task automatic set_inputs(input logic [N-1:0] rv, input bit rdy, input bit rtv,
                              input int rtag, input logic [N-1:0] ry);
        for (int i = 0; i < N; i++) pk[i] = rand_pkt();
        bus.req_v_i            = rv;
        bus.req_packet_i       = {pk[2], pk[1], pk[0]};
        bus.link_ready_i       = rdy;
        bus.link_return_v_i    = rtv;
        bus.link_return_data_i = {$urandom, $urandom};
        bus.link_return_id_i   = {rtag[1:0], 3'($urandom_range(0, 7))};
        bus.ret_yumi_i         = ry;
    endtask

    // called just after a negedge with inputs applied: check outputs, then advance the model by one clock
    task automatic step();
        bit            can;
        int            g;
        int            idx;
        int            t;
        logic [N-1:0]  exp_ready;
        logic [N-1:0]  exp_rv;
        bit            exp_yumi;
        logic [N*CW-1:0] exp_cr;
        bit            all_zero;
        #1;
        can = !m_full || bus.link_ready_i;
        g = -1;
        if (can) begin
            for (int k = 1; k <= N; k++) begin
`ifdef LOADER_ARB_FIXED_PRIO_EN
                idx = k - 1;
`else
                idx = (m_last + k) % N;
`endif
                if (g < 0 && bus.req_v_i[idx] && m_cnt[idx] < MAX) g = idx;
            end
        end
        exp_ready = (g >= 0) ? N'(1 << g) : '0;
        t = int'(bus.link_return_id_i) >> TPOS;
        if (t < N) begin
            exp_rv   = bus.link_return_v_i ? N'(1 << t) : '0;
            exp_yumi = bus.link_return_v_i && bus.ret_yumi_i[t];
        end else begin
            exp_rv   = '0;
            exp_yumi = bus.link_return_v_i;
        end
        all_zero = 1;
        for (int i = 0; i < N; i++) begin
            exp_cr[i*CW +: CW] = CW'(m_cnt[i]);
            if (m_cnt[i] != 0) all_zero = 0;
        end
        chk("req_ready", PW'(bus.req_ready_o), PW'(exp_ready));
        chk("link_v", PW'(bus.link_v_o), PW'(m_full));
        if (m_full) chk("link_packet", bus.link_packet_o, m_pkt);
        chk("ret_v", PW'(bus.ret_v_o), PW'(exp_rv));
        chk("ret_yumi", PW'(bus.link_return_yumi_o), PW'(exp_yumi));
        chk("ret_data", PW'(bus.ret_data_o), PW'(bus.link_return_data_i));
        chk("credits", PW'(bus.out_credits_o), PW'(exp_cr));
        chk("idle", PW'(bus.idle_o), PW'(!m_full && all_zero));
        chk("err", PW'(bus.err_o), PW'(m_err));
        // consequences of this cycle, seen after the next clock edge
        if (exp_yumi) begin
            if (t >= N || m_cnt[t] == 0) m_err = 1;
            else m_cnt[t]--;
        end
        if (can) begin
            m_full = (g >= 0);
            if (g >= 0) begin
                m_pkt = (pk[g] & ~(PW'(3) << TPOS)) | (PW'(g) << TPOS);
                m_cnt[g]++;
                m_last = g;
            end
        end
        @(negedge clk);
    endtask

    task automatic rand_cycle();
        int tag;
        tag = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, N - 1);
        set_inputs(N'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 1) == 1), tag, N'($urandom_range(0, 7)));
    endtask

    initial begin
        model_reset();
        // reset state with activity on the inputs
        set_inputs(3'b111, 1'b1, 1'b1, 3, 3'b111);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", PW'(bus.req_ready_o), PW'(0));
        chk("rst_yumi", PW'(bus.link_return_yumi_o), PW'(0));
        chk("rst_link_v", PW'(bus.link_v_o), PW'(0));
        chk("rst_idle", PW'(bus.idle_o), PW'(1));
        chk("rst_err", PW'(bus.err_o), PW'(0));
        chk("rst_credits", PW'(bus.out_credits_o), PW'(0));
        @(negedge clk);
        reset_i = 1'b1;

        // all requesting, link always ready, no returns
        repeat (8) begin
            set_inputs(3'b111, 1'b1, 1'b0, 0, 3'b000);
            step();
        end
        // link stalls with the buffer full
        repeat (5) begin
            set_inputs(3'b111, 1'b0, 1'b0, 0, 3'b000);
            step();
        end
        // requester 1 alone until it runs out of credits
        repeat (10) begin
            set_inputs(3'b010, 1'b1, 1'b0, 0, 3'b000);
            step();
        end
        // return for tag 2 held until consumed
        repeat (3) begin
            set_inputs(3'b000, 1'b1, 1'b1, 2, 3'b000);
            step();
        end
        set_inputs(3'b000, 1'b1, 1'b1, 2, 3'b100);
        step();
        // out-of-range tag
        set_inputs(3'b000, 1'b1, 1'b1, 3, 3'b000);
        step();

        repeat (1500) begin
            rand_cycle();
            step();
        end

        // fill the buffer, then reset asynchronously between edges
        repeat (3) begin
            set_inputs(3'b111, 1'b0, 1'b0, 0, 3'b000);
            step();
        end
        #2 reset_i = 1'b0;
        #1;
        chk("arst_link_v", PW'(bus.link_v_o), PW'(0));
        chk("arst_credits", PW'(bus.out_credits_o), PW'(0));
        chk("arst_ready", PW'(bus.req_ready_o), PW'(0));
        chk("arst_idle", PW'(bus.idle_o), PW'(1));
        model_reset();
        @(negedge clk);
        reset_i = 1'b1;
        repeat (20) begin
            set_inputs(3'b111, 1'b1, 1'b0, 0, 3'b000);
            step();
        end
        repeat (300) begin
            rand_cycle();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
